// File: rtl/alu_req_arb.sv
// Two-master round-robin front end for the ALU: one-entry registered request
// stage, an order FIFO of grant sources, and in-order response routing.
module alu_req_arb #(
   parameter int ORD_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m0_req_valid,
   output logic                         m0_req_ready,
   input  logic [2:0]                   m0_req_op,
   input  logic [7:0]                   m0_req_op1,
   input  logic [7:0]                   m0_req_op2,
   input  logic                         m1_req_valid,
   output logic                         m1_req_ready,
   input  logic [2:0]                   m1_req_op,
   input  logic [7:0]                   m1_req_op1,
   input  logic [7:0]                   m1_req_op2,
   output logic                         m0_resp_valid,
   input  logic                         m0_resp_ready,
   output logic [15:0]                  m0_resp_result,
   output logic                         m1_resp_valid,
   input  logic                         m1_resp_ready,
   output logic [15:0]                  m1_resp_result,
   output logic                         alu_req_valid,
   input  logic                         alu_req_ready,
   output logic [2:0]                   alu_req_op,
   output logic [7:0]                   alu_req_op1,
   output logic [7:0]                   alu_req_op2,
   input  logic                         alu_resp_valid,
   output logic                         alu_resp_ready,
   input  logic [15:0]                  alu_resp_result,
   output logic [$clog2(ORD_DEPTH):0]   outstanding,
   output logic                         err_orphan
);

   localparam int PW = $clog2(ORD_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(ORD_DEPTH);

   // Every channel transfers on a cycle where valid && ready are both high;
   // a held valid keeps its payload stable until that cycle.
   logic                 out_valid;
   logic [2:0]           out_op;
   logic [7:0]           out_op1;
   logic [7:0]           out_op2;
   logic                 rr;
   logic [PW:0]          count;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [ORD_DEPTH-1:0] ord_mem;

   logic load_ok, ord_full, ord_empty, grant_ok, sel;
   logic acc0, acc1, push, pop, head;

   assign ord_full  = (count == FULL_CNT);
   assign ord_empty = (count == '0);
   assign load_ok   = !out_valid || alu_req_ready;
   assign grant_ok  = load_ok && !ord_full && !rst;
   assign head      = ord_mem[rd_ptr];

   // sel names the master that owns the grant this cycle; rr breaks ties.
   always_comb begin
      sel = rr;
      if (m0_req_valid && m1_req_valid) sel = rr;
      else if (m0_req_valid)            sel = 1'b0;
      else if (m1_req_valid)            sel = 1'b1;
   end

   assign m0_req_ready = grant_ok && !sel;
   assign m1_req_ready = grant_ok && sel;
   assign acc0 = m0_req_valid && m0_req_ready;
   assign acc1 = m1_req_valid && m1_req_ready;
   assign push = acc0 || acc1;

   assign m0_resp_valid  = alu_resp_valid && !ord_empty && !head;
   assign m1_resp_valid  = alu_resp_valid && !ord_empty && head;
   assign m0_resp_result = alu_resp_result;
   assign m1_resp_result = alu_resp_result;
   assign alu_resp_ready = !ord_empty && (head ? m1_resp_ready : m0_resp_ready);
   assign pop = alu_resp_valid && alu_resp_ready;

   assign alu_req_valid = out_valid;
   assign alu_req_op    = out_op;
   assign alu_req_op1   = out_op1;
   assign alu_req_op2   = out_op2;
   assign outstanding   = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_op     <= '0;
         out_op1    <= '0;
         out_op2    <= '0;
         rr         <= 1'b0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (push) begin
            out_valid <= 1'b1;
            out_op    <= acc1 ? m1_req_op  : m0_req_op;
            out_op1   <= acc1 ? m1_req_op1 : m0_req_op1;
            out_op2   <= acc1 ? m1_req_op2 : m0_req_op2;
            rr        <= !acc1;
            wr_ptr    <= wr_ptr + 1'b1;
         end else if (alu_req_ready) begin
            out_valid <= 1'b0;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (alu_resp_valid && ord_empty) err_orphan <= 1'b1;
      end
   end

   // Order entries need no reset: only slots behind wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (push) ord_mem[wr_ptr] <= acc1;
   end

endmodule

// File: tb/tb_alu_req_arb.sv
// Self-checking bench for alu_req_arb: the bench plays both masters and the ALU,
// and a scoreboard tracks request payloads, grant order and routed responses.
module tb_alu_req_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_valid, m0_req_ready, m1_req_valid, m1_req_ready;
   logic [2:0]  m0_req_op, m1_req_op;
   logic [7:0]  m0_req_op1, m0_req_op2, m1_req_op1, m1_req_op2;
   logic        m0_resp_valid, m0_resp_ready, m1_resp_valid, m1_resp_ready;
   logic [15:0] m0_resp_result, m1_resp_result;
   logic        alu_req_valid, alu_req_ready;
   logic [2:0]  alu_req_op;
   logic [7:0]  alu_req_op1, alu_req_op2;
   logic        alu_resp_valid, alu_resp_ready;
   logic [15:0] alu_resp_result;
   logic [3:0]  outstanding;
   logic        err_orphan;

   int total = 0;
   int bad   = 0;

   logic [19:0] req_q[$];   // {src, op, op1, op2} in grant order
   logic [0:0]  src_q[$];   // source of each outstanding request
   logic [15:0] alu_q[$];   // model results for requests the ALU has taken

   alu_req_arb #(.ORD_DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
      .m0_req_op(m0_req_op), .m0_req_op1(m0_req_op1), .m0_req_op2(m0_req_op2),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
      .m1_req_op(m1_req_op), .m1_req_op1(m1_req_op1), .m1_req_op2(m1_req_op2),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
      .m0_resp_result(m0_resp_result),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
      .m1_resp_result(m1_resp_result),
      .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
      .alu_req_op(alu_req_op), .alu_req_op1(alu_req_op1), .alu_req_op2(alu_req_op2),
      .alu_resp_valid(alu_resp_valid), .alu_resp_ready(alu_resp_ready),
      .alu_resp_result(alu_resp_result),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      case (op)
         3'd0:    return {8'd0, a} + {8'd0, b};
         3'd1:    return {8'd0, a} - {8'd0, b};
         3'd2:    return {8'd0, a} * {8'd0, b};
         default: return {8'd0, a ^ b};
      endcase
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [19:0] e;
      logic [0:0]  s;
      logic [15:0] r;
      if (rst) begin
         req_q.delete();
         src_q.delete();
         alu_q.delete();
      end else begin
         chk("ready_excl", {31'd0, m0_req_ready & m1_req_ready}, 32'd0);
         if (alu_req_valid && alu_req_ready) begin
            if (req_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
            else begin
               e = req_q.pop_front();
               chk("req_payload", {13'd0, alu_req_op, alu_req_op1, alu_req_op2}, {13'd0, e[18:0]});
               alu_q.push_back(alu_model(e[18:16], e[15:8], e[7:0]));
            end
         end
         if (alu_resp_valid && alu_resp_ready) begin
            if (src_q.size() == 0 || alu_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else begin
               s = src_q.pop_front();
               r = alu_q.pop_front();
               chk("resp_route", {30'd0, m1_resp_valid, m0_resp_valid}, s[0] ? 32'd2 : 32'd1);
               chk("resp_result", {16'd0, s[0] ? m1_resp_result : m0_resp_result}, {16'd0, r});
            end
         end
         if (m0_req_valid && m0_req_ready) begin
            req_q.push_back({1'b0, m0_req_op, m0_req_op1, m0_req_op2});
            src_q.push_back(1'b0);
         end
         if (m1_req_valid && m1_req_ready) begin
            req_q.push_back({1'b1, m1_req_op, m1_req_op1, m1_req_op2});
            src_q.push_back(1'b1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic set_m0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      m0_req_valid = v; m0_req_op = op; m0_req_op1 = a; m0_req_op2 = b;
   endtask

   task automatic set_m1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      m1_req_valid = v; m1_req_op = op; m1_req_op1 = a; m1_req_op2 = b;
   endtask

   // Return the oldest ALU result; ends just after its handshake edge.
   task automatic resp_one();
      int n;
      n = 0;
      while (alu_q.size() == 0 && n < 20) begin cyc(); n++; end
      if (alu_q.size() == 0) begin
         chk("resp_avail", 32'd0, 32'd1);
         return;
      end
      alu_resp_valid  = 1'b1;
      alu_resp_result = alu_q[0];
      #1;
      n = 0;
      while (!alu_resp_ready && n < 20) begin cyc(); #1; n++; end
      chk("resp_ready", {31'd0, alu_resp_ready}, 32'd1);
      cyc();
      alu_resp_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g;
      logic w;
      logic [2:0] op0, op1;
      logic [7:0] a0, b0, a1, b1;
      rst = 1'b1;
      set_m0(1'b1, 3'd0, 8'd1, 8'd1);
      set_m1(1'b1, 3'd0, 8'd2, 8'd2);
      m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
      alu_req_ready = 1'b1; alu_resp_valid = 1'b0; alu_resp_result = '0;
      cyc(); cyc(); #1;
      chk("rst_req_valid", {31'd0, alu_req_valid}, 32'd0);
      chk("rst_payload", {13'd0, alu_req_op, alu_req_op1, alu_req_op2}, 32'd0);
      chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
      chk("rst_err", {31'd0, err_orphan}, 32'd0);
      chk("rst_readies", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      chk("rst_resp", {29'd0, alu_resp_ready, m1_resp_valid, m0_resp_valid}, 32'd0);
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      set_m1(1'b0, 3'd0, 8'd0, 8'd0);
      rst = 1'b0;
      cyc();

      // single request: ADD 3,4 from m0
      set_m0(1'b1, 3'd0, 8'd3, 8'd4);
      #1 chk("single_grant", {31'd0, m0_req_ready}, 32'd1);
      cyc();
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      #1;
      chk("single_valid", {31'd0, alu_req_valid}, 32'd1);
      chk("single_payload", {13'd0, alu_req_op, alu_req_op1, alu_req_op2}, {13'd0, 3'd0, 8'd3, 8'd4});
      chk("single_out1", {28'd0, outstanding}, 32'd1);
      cyc();
      alu_resp_valid = 1'b1; alu_resp_result = 16'd7;
      #1;
      chk("single_resp", {30'd0, m1_resp_valid, m0_resp_valid}, 32'd1);
      chk("single_result", {16'd0, m0_resp_result}, 32'd7);
      cyc();
      alu_q.delete();
      alu_resp_valid = 1'b0;
      #1 chk("single_out0", {28'd0, outstanding}, 32'd0);

      // round robin with both masters always valid
      do_reset();
      op0 = 3'($urandom_range(0, 3)); a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
      op1 = 3'($urandom_range(0, 3)); a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
      set_m0(1'b1, op0, a0, b0);
      set_m1(1'b1, op1, a1, b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_order", {30'd0, m1_req_ready, m0_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         cyc();
      end
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      set_m1(1'b0, 3'd0, 8'd0, 8'd0);
      for (int i = 0; i < 4; i++) resp_one();

      // order routing with a stalled m1 response port
      set_m1(1'b1, 3'd1, 8'd9, 8'd2);
      cyc();
      set_m1(1'b0, 3'd0, 8'd0, 8'd0);
      set_m0(1'b1, 3'd2, 8'd5, 8'd5);
      cyc();
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      cyc();
      m1_resp_ready = 1'b0;
      alu_resp_valid = 1'b1; alu_resp_result = 16'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("route_stall_rdy", {31'd0, alu_resp_ready}, 32'd0);
         chk("route_stall_m0", {31'd0, m0_resp_valid}, 32'd0);
         chk("route_stall_m1", {31'd0, m1_resp_valid}, 32'd1);
         cyc();
      end
      m1_resp_ready = 1'b1;
      alu_resp_valid = 1'b0;
      resp_one();
      resp_one();

      // full order FIFO
      set_m0(1'b1, 3'd0, 8'd1, 8'd1);
      set_m1(1'b1, 3'd0, 8'd2, 8'd2);
      g = 0;
      for (int i = 0; i < 12; i++) begin
         m0_req_op1 = 8'($urandom_range(0, 255));
         m1_req_op2 = 8'($urandom_range(0, 255));
         #1;
         if (m0_req_ready || m1_req_ready) g++;
         cyc();
      end
      #1;
      chk("full_grants", g, 32'd8);
      chk("full_outstanding", {28'd0, outstanding}, 32'd8);
      chk("full_readies", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      resp_one();
      #1 chk("full_regrant", {31'd0, m0_req_ready | m1_req_ready}, 32'd1);
      cyc();
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      set_m1(1'b0, 3'd0, 8'd0, 8'd0);
      for (int i = 0; i < 8; i++) resp_one();
      chk("full_drained", {28'd0, outstanding}, 32'd0);

      // output stall
      alu_req_ready = 1'b0;
      set_m0(1'b1, 3'd3, 8'h5a, 8'h0f);
      set_m1(1'b1, 3'd2, 8'h11, 8'h22);
      #1;
      chk("stall_one_grant", {31'd0, m0_req_ready ^ m1_req_ready}, 32'd1);
      w = m1_req_ready;
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_readies", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
         chk("stall_payload", {13'd0, alu_req_op, alu_req_op1, alu_req_op2},
             w ? {13'd0, 3'd2, 8'h11, 8'h22} : {13'd0, 3'd3, 8'h5a, 8'h0f});
         cyc();
      end
      alu_req_ready = 1'b1;
      #1 chk("stall_rr_next", {30'd0, m1_req_ready, m0_req_ready}, w ? 32'd1 : 32'd2);
      cyc();
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      set_m1(1'b0, 3'd0, 8'd0, 8'd0);
      resp_one();
      resp_one();

      // orphan response, then reset with requests outstanding
      do_reset();
      alu_resp_valid = 1'b1; alu_resp_result = 16'hdead;
      #1;
      chk("orphan_ready", {31'd0, alu_resp_ready}, 32'd0);
      chk("orphan_route", {30'd0, m1_resp_valid, m0_resp_valid}, 32'd0);
      cyc();
      alu_resp_valid = 1'b0;
      #1 chk("orphan_err", {31'd0, err_orphan}, 32'd1);
      set_m0(1'b1, 3'd0, 8'd7, 8'd8);
      cyc(); cyc(); cyc();
      alu_req_ready = 1'b0;
      set_m0(1'b0, 3'd0, 8'd0, 8'd0);
      #1;
      chk("mid_outstanding", {28'd0, outstanding}, 32'd3);
      chk("mid_held", {31'd0, alu_req_valid}, 32'd1);
      rst = 1'b1;
      cyc();
      #1;
      chk("mid_rst_out", {28'd0, outstanding}, 32'd0);
      chk("mid_rst_valid", {31'd0, alu_req_valid}, 32'd0);
      chk("mid_rst_err", {31'd0, err_orphan}, 32'd0);
      rst = 1'b0;
      alu_req_ready = 1'b1;
      alu_resp_valid = 1'b1; alu_resp_result = 16'h0bad;
      cyc();
      alu_resp_valid = 1'b0;
      #1 chk("post_rst_orphan", {31'd0, err_orphan}, 32'd1);

      cyc();
      chk("sb_req_empty", req_q.size(), 32'd0);
      chk("sb_src_empty", src_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_req_arb.md
# alu_req_arb

Two-master front end for the ALU. It round-robin arbitrates two requesters onto the single ALU request channel through a one-entry registered output stage. It records the order in which grants were issued and routes each in-order ALU response back to the master that issued the request. The block sits directly upstream of the ALU: its `alu_req_*` ports drive the ALU request interface, and its `alu_resp_*` ports consume the ALU response interface.

## Interface
Parameters:
- `ORD_DEPTH`, default 8 — order-FIFO depth, i.e. the maximum number of outstanding requests. Power of two, ≥2.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `m0_req_valid` / `m1_req_valid`  in  1  — master request valid.
- `m0_req_ready` / `m1_req_ready`  out  1  — master request ready (grant).
- `m0_req_op` / `m1_req_op`  in  3  — opcode.
- `m0_req_op1` / `m1_req_op1`  in  8  — operand 1.
- `m0_req_op2` / `m1_req_op2`  in  8  — operand 2.
- `m0_resp_valid` / `m1_resp_valid`  out  1  — response valid to master.
- `m0_resp_ready` / `m1_resp_ready`  in  1  — master response ready.
- `m0_resp_result` / `m1_resp_result`  out  16  — response data; both carry `alu_resp_result`.
- `alu_req_valid`  out  1  — request to ALU.
- `alu_req_ready`  in  1  — ALU ready.
- `alu_req_op`  out  3  — registered opcode.
- `alu_req_op1`  out  8  — registered operand 1.
- `alu_req_op2`  out  8  — registered operand 2.
- `alu_resp_valid`  in  1  — ALU response valid.
- `alu_resp_ready`  out  1  — ready to ALU.
- `alu_resp_result`  in  16  — ALU result.
- `outstanding`  out  $clog2(ORD_DEPTH)+1  — order-FIFO occupancy.
- `err_orphan`  out  1  — sticky flag: ALU response arrived with nothing outstanding.

## Operation
- **Output stage.** A register holds `{valid, op, op1, op2}`. `load_ok = !out_valid || alu_req_ready`.
- **Grant condition.** Grant is possible only when `load_ok && !ord_full && !rst`.
- **Round-robin arbitration.** The `rr` bit names the priority master; reset value is 0 (m0 first).
  - Both valid: the `rr` master wins.
  - One valid: that master wins.
  - After any grant, `rr` becomes the other master.
  - No grant: `rr` is unchanged.
- **Request ready.** `mX_req_ready` is combinational and asserted only for the winning master. At most one ready is high per cycle. Ready does not depend on the master's own valid beyond arbitration.
- **Accept.** Accept = `mX_req_valid && mX_req_ready`. On accept:
  - the output register loads that master's op/op1/op2;
  - `out_valid` is set to 1;
  - the source ID X is pushed into the order FIFO.
- **Output register release.** On `alu_req_valid && alu_req_ready` with no new accept, `out_valid` clears. The payload registers hold their last values.
- **Response routing.** Responses are routed by the order-FIFO head:
  - `mX_resp_valid = alu_resp_valid && !ord_empty && head==X`.
  - `alu_resp_ready = !ord_empty && (head==0 ? m0_resp_ready : m1_resp_ready)`.
- **Order-FIFO pop.** The FIFO pops on `alu_resp_valid && alu_resp_ready`.
- **Simultaneous push and pop.** Pointers advance, count is unchanged. A push is allowed when full only if… no: a push is never allowed when full, even with a same-cycle pop. Full blocks grant combinationally, so throughput at depth is intentionally conservative.
- **Orphan response.** `alu_resp_valid` while `ord_empty` is a protocol violation: `alu_resp_ready` stays 0 and `err_orphan` is set. `err_orphan` clears only on `rst`.
- **Pointer width.** Pointers are `$clog2(ORD_DEPTH)` bits and wrap naturally. Count is one bit wider.

## Timing
- **Reset values** (any cycle `rst` is high, synchronous):
  - `alu_req_valid`=0; `alu_req_op`/`op1`/`op2`=0;
  - `outstanding`=0; `err_orphan`=0; `rr`=0;
  - order FIFO empty.
  - While `rst` is high, all `mX_req_ready`=0.
  - With the FIFO empty, `mX_resp_valid`=0 and `alu_resp_ready`=0.
- **Reset mid-operation.** The held request and all outstanding order entries are discarded. Responses the ALU returns afterwards count as orphans.
- **Request latency.** Accept at edge N → `alu_req_valid`=1 with that payload after edge N, i.e. visible in cycle N+1.
- **Back-to-back requests.** With `alu_req_ready` held high, one request per cycle is sustained.
- **Stall.** With `alu_req_ready`=0 and `out_valid`=1, both `mX_req_ready`=0. The payload is stable until accepted.
- **Response path.** Zero latency, combinational pass-through.
- **Occupancy.** `outstanding` updates the cycle after push/pop.

## Test plan
- **Single request.** Reset; m0 sends ADD 3,4; `alu_req_ready`=1 → `alu_req_*`={0,3,4} one cycle after accept; the ALU returns 7 → `m0_resp_valid`=1, result 7, `m1_resp_valid`=0, `outstanding` goes 1→0.
- **Round robin.** Both masters hold valid for 4 grants with ALU ready → grant order m0, m1, m0, m1; `m0_req_ready` and `m1_req_ready` never high together.
- **Order routing.** Grant m1 (SUB 9,2), then m0 (MUL 5,5). Responses 7 then 25 → 7 delivered on m1, 25 on m0. With `m1_resp_ready`=0 for 3 cycles, `alu_resp_ready`=0 and m0 receives nothing until m1 accepts.
- **Full FIFO.** Generate `ORD_DEPTH` grants with no ALU responses → `outstanding`=8 and both readies 0. One response popped → the next grant occurs the following cycle.
- **Output stall.** Hold `alu_req_ready`=0 for 5 cycles after a grant → payload constant, no further grants, `rr` unchanged.
- **Orphan response and reset.** Drive `alu_resp_valid` after reset with no requests → `err_orphan`=1 next cycle, `alu_resp_ready`=0. Assert `rst` with 3 outstanding → next cycle `outstanding`=0, `alu_req_valid`=0, `err_orphan`=0.
